core_arb: RTL and testbench



---
 rtl/core_arb.sv | 210 +++++++++++++++++++++
 tb/tb_core_arb.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_arb.sv
// rtl/core_arb.sv - round-robin arbiter/sequencer sharing one fixed-latency 8-bit core; optional CORE_ARB_PRIO0_EN gives requester 0 strict priority
`timescale 1ns/1ps

module core_arb #(
    parameter int NUM_REQ  = 4,
    parameter int CORE_LAT = 3,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW      = $clog2(CORE_LAT + 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   core_a,
    output logic [7:0]             core_b,
    input  logic [7:0]             core_c,
    input  logic                   core_d,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [7:0]             rsp_data,
    output logic                   rsp_flag,
    output logic                   idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  core_a_q, core_a_d;
    logic [7:0]            core_b_q, core_b_d;
    logic [IDW-1:0]        issue_id_q, issue_id_d;
    logic [CORE_LAT-1:0]   tag_v_q, tag_v_d;
    logic [IDW-1:0]        tag_id_q [CORE_LAT];
    logic [IDW-1:0]        tag_id_d [CORE_LAT];
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    logic [7:0]            rsp_data_q, rsp_data_d;
    logic                  rsp_flag_q, rsp_flag_d;
    logic                  idle_q, idle_d;

    logic                  gnt_found;
    logic [IDW-1:0]        gnt_id;
    logic [7:0]            gnt_data;
    logic                  tag_out_v;

    // Grant search: only in RUN, starting at ptr and wrapping; ready is never raised without valid
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        gnt_found = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        idx       = 0;
        idx_w     = '0;
        if (state_q == ST_RUN) begin
`ifdef CORE_ARB_PRIO0_EN
            if (req_valid[0]) begin
                gnt_found = 1'b1;
                gnt_id    = '0;
            end
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_w = IDW'(idx);
`ifdef CORE_ARB_PRIO0_EN
                if (!gnt_found && (idx_w != '0) && req_valid[idx_w]) begin
`else
                if (!gnt_found && req_valid[idx_w]) begin
`endif
                    gnt_found = 1'b1;
                    gnt_id    = idx_w;
                end
            end
            if (gnt_found) begin
                req_ready[gnt_id] = 1'b1;
            end
        end
    end

    assign gnt_data  = req_data[{gnt_id, 3'b000} +: 8];
    assign tag_out_v = tag_v_q[CORE_LAT-1];

    // Pointer advances past the winner; strict-priority grants to requester 0 leave it alone
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) begin
`ifdef CORE_ARB_PRIO0_EN
            if (gnt_id != '0) begin
                ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            end
`else
            ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
`endif
        end
    end

    // Mode FSM: en starts/stops granting; DRAIN waits for every accepted op to come back
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (count_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue register and tag pipeline; the tag leaves the pipe in the cycle the core result is valid
    always_comb begin
        core_a_d   = gnt_found;
        core_b_d   = gnt_found ? gnt_data : core_b_q;
        issue_id_d = gnt_found ? gnt_id : issue_id_q;
        tag_v_d    = '0;
        tag_v_d[0] = core_a_q;
        tag_id_d[0] = issue_id_q;
        for (int k = 1; k < CORE_LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    // Response capture: core_c/core_d are only looked at when a tag is due
    always_comb begin
        rsp_valid_d = tag_out_v;
        rsp_id_d    = tag_out_v ? tag_id_q[CORE_LAT-1] : rsp_id_q;
        rsp_data_d  = tag_out_v ? core_c : rsp_data_q;
        rsp_flag_d  = tag_out_v ? core_d : rsp_flag_q;
    end

    // In-flight count from handshake to result return; bounded by CORE_LAT+1
    always_comb begin
        count_d = count_q;
        case ({gnt_found, tag_out_v})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        idle_d = (state_q == ST_IDLE) && (count_q == '0);
    end

    // State registers; reset discards all in-flight tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            core_a_q    <= 1'b0;
            core_b_q    <= '0;
            issue_id_q  <= '0;
            tag_v_q     <= '0;
            for (int k = 0; k < CORE_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            issue_id_q  <= issue_id_d;
            tag_v_q     <= tag_v_d;
            for (int k = 0; k < CORE_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flag_q  <= rsp_flag_d;
            idle_q      <= idle_d;
        end
    end

    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_core_arb.sv
// tb/tb_core_arb.sv - self-checking bench for core_arb with a queue-based reference model
`timescale 1ns/1ps

module tb_core_arb;

    localparam int NUM_REQ  = 4;
    localparam int CORE_LAT = 3;
    localparam int IDW      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 core_a;
    logic [7:0]           core_b;
    logic [7:0]           core_c;
    logic                 core_d;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_flag;
    logic                 idle;

    core_arb #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_flag(rsp_flag), .idle(idle)
    );

    always #5 clk = ~clk;

    // Core model: result = operand+1, flag = ~operand[0], CORE_LAT cycles after issue; junk otherwise
    logic [7:0] pd [CORE_LAT];
    logic       pf [CORE_LAT];
    always @(posedge clk) begin
        pd[0] <= core_a ? core_b + 8'd1 : 8'($urandom);
        pf[0] <= core_a ? ~core_b[0] : 1'($urandom);
        for (int k = 1; k < CORE_LAT; k++) begin
            pd[k] <= pd[k-1];
            pf[k] <= pf[k-1];
        end
    end
    assign core_c = pd[CORE_LAT-1];
    assign core_d = pf[CORE_LAT-1];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int data;
        int flag;
        int hs;
        int due;
    } exp_t;
    exp_t eq[$];

    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_data[$];
    int r_flag[$];
    int r_cyc[$];

    int m_state;       // 0 idle, 1 run, 2 drain
    int m_ptr;
    int m_prev_idle;
    int m_issue;
    int m_issue_data;

    // Reference model and scoreboard, evaluated once per cycle away from the active edge
    always @(negedge clk) begin : monitor
        int g;
        int inflight;
        int d;
        logic [NUM_REQ-1:0] exp_ready;
        logic exp_rv;
        cyc++;
        if (!rst_n) begin
            eq.delete();
            m_state = 0; m_ptr = 0; m_prev_idle = 1; m_issue = 0; m_issue_data = 0;
            n_cmp++;
            if (req_ready !== '0 || core_a !== 1'b0 || rsp_valid !== 1'b0 || idle !== 1'b1) begin
                n_fail++;
                $display("FAIL in_reset: ready=%b core_a=%b rsp_valid=%b idle=%b, need 0000 0 0 1",
                         req_ready, core_a, rsp_valid, idle);
            end
        end else begin
            inflight = 0;
            foreach (eq[k]) if (eq[k].hs < cyc && eq[k].due > cyc) inflight++;
            g = -1;
            if (m_state == 1) begin
`ifdef CORE_ARB_PRIO0_EN
                if (req_valid[0]) g = 0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    int idx;
                    idx = (m_ptr + i) % NUM_REQ;
                    if (g < 0 && idx != 0 && req_valid[idx]) g = idx;
                end
`else
                for (int i = 0; i < NUM_REQ; i++) begin
                    int idx;
                    idx = (m_ptr + i) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
`endif
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL req_ready cyc %0d: got %b need %b", cyc, req_ready, exp_ready);
            end
            n_cmp++;
            if (core_a !== 1'(m_issue) || (m_issue != 0 && core_b !== 8'(m_issue_data))) begin
                n_fail++;
                $display("FAIL issue cyc %0d: got a=%b b=%h need a=%0d b=%h", cyc, core_a, core_b, m_issue, m_issue_data);
            end
            n_cmp++;
            if (idle !== 1'(m_prev_idle)) begin
                n_fail++;
                $display("FAIL idle cyc %0d: got %b need %0d", cyc, idle, m_prev_idle);
            end
            exp_rv = (eq.size() > 0) && (eq[0].due == cyc);
            n_cmp++;
            if (rsp_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL rsp_valid cyc %0d: got %b need %b", cyc, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                n_cmp++;
                if (rsp_id !== IDW'(eq[0].id) || rsp_data !== 8'(eq[0].data) || rsp_flag !== 1'(eq[0].flag)) begin
                    n_fail++;
                    $display("FAIL rsp_fields cyc %0d: got id=%0d d=%h f=%b need id=%0d d=%h f=%0d",
                             cyc, rsp_id, rsp_data, rsp_flag, eq[0].id, eq[0].data, eq[0].flag);
                end
                void'(eq.pop_front());
            end
            if (rsp_valid === 1'b1) begin
                r_id.push_back(int'(rsp_id)); r_data.push_back(int'(rsp_data));
                r_flag.push_back(int'(rsp_flag)); r_cyc.push_back(cyc);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1) begin
                    g_id.push_back(i); g_cyc.push_back(cyc);
                end
            end
            m_issue = 0;
            if (g >= 0) begin
                exp_t e;
                d = int'(req_data[8*g +: 8]);
                e.id = g; e.data = (d + 1) % 256; e.flag = (d % 2 == 0) ? 1 : 0;
                e.hs = cyc; e.due = cyc + 2 + CORE_LAT;
                eq.push_back(e);
`ifdef CORE_ARB_PRIO0_EN
                if (g != 0) m_ptr = (g + 1) % NUM_REQ;
`else
                m_ptr = (g + 1) % NUM_REQ;
`endif
                m_issue = 1;
                m_issue_data = d;
            end
            m_prev_idle = (m_state == 0 && inflight == 0) ? 1 : 0;
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!en) m_state = 2;
                default: if (en) m_state = 1; else if (inflight == 0) m_state = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; en = 1'b0; req_valid = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_data = 32'hA5A5_A5A5;
        step(); step();
        n_cmp++;
        if (req_ready !== '0 || core_a !== 1'b0 || core_b !== 8'h00 || rsp_valid !== 1'b0 ||
            rsp_id !== '0 || rsp_data !== 8'h00 || rsp_flag !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b a=%b b=%h rv=%b id=%0d d=%h f=%b idle=%b",
                     req_ready, core_a, core_b, rsp_valid, rsp_id, rsp_data, rsp_flag, idle);
        end
        req_valid = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int gb, rb, hs;
        bit got;
        reset_dut();
        gb = g_id.size(); rb = r_id.size();
        en = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'h5A;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (g_id.size() > gb) begin got = 1; req_valid = '0; end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL single_grant: got none need 1 grant"); return; end
        hs = g_cyc[gb];
        n_cmp++;
        if (g_id[gb] != 2 || core_a !== 1'b1 || core_b !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_issue: got id=%0d a=%b b=%h need id=2 a=1 b=5a", g_id[gb], core_a, core_b);
        end
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (r_id.size() > rb) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++; $display("FAIL single_rsp: got no response need 1");
        end else if (r_cyc[rb] - hs != 2 + CORE_LAT || r_id[rb] != 2 || r_data[rb] != 8'h5B || r_flag[rb] != 1) begin
            n_fail++;
            $display("FAIL single_rsp: got lat=%0d id=%0d d=%h f=%0d need lat=%0d id=2 d=5b f=1",
                     r_cyc[rb] - hs, r_id[rb], r_data[rb], r_flag[rb], 2 + CORE_LAT);
        end
        en = 1'b0;
        got = 0;
        for (int t = 0; t < 12 && !got; t++) begin
            step();
            if (idle === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL single_idle: got idle=%b need 1", idle); end
    endtask

    task automatic test_contention();
        int gb, rb, e;
        bit got;
        reset_dut();
        gb = g_id.size(); rb = r_id.size();
        en = 1'b1; req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'($urandom);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (g_id.size() >= gb + 8) begin got = 1; req_valid = '0; end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL contention_grants: got %0d need 8", g_id.size() - gb); return; end
        for (int i = 0; i < 8; i++) begin
`ifdef CORE_ARB_PRIO0_EN
            e = 0;
`else
            e = i % NUM_REQ;
`endif
            n_cmp++;
            if (g_id[gb+i] != e) begin
                n_fail++; $display("FAIL contention_order[%0d]: got %0d need %0d", i, g_id[gb+i], e);
            end
        end
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (r_id.size() >= rb + 8) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++; $display("FAIL contention_rsps: got %0d need 8", r_id.size() - rb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (r_id[rb+i] != g_id[gb+i]) begin
                    n_fail++; $display("FAIL contention_rsp_id[%0d]: got %0d need %0d", i, r_id[rb+i], g_id[gb+i]);
                end
            end
        end
        en = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_drain();
        int gb, rb;
        bit got;
        gb = g_id.size(); rb = r_id.size();
        en = 1'b1; req_valid = '0;
        step();
        req_valid = '1;
        step();
        step();
        en = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (g_id.size() - gb != 3) begin
            n_fail++; $display("FAIL drain_grants: got %0d need 3", g_id.size() - gb);
        end
        req_valid = '0;
        got = 0;
        for (int t = 0; t < 15 && !got; t++) begin
            if (idle === 1'b1) got = 1; else step();
        end
        n_cmp++;
        if (!got || r_id.size() - rb != 3) begin
            n_fail++; $display("FAIL drain_done: got idle=%b rsps=%0d need idle=1 rsps=3", idle, r_id.size() - rb);
        end
    endtask

    task automatic test_abort();
        int gb, rb;
        bit got;
        gb = g_id.size(); rb = r_id.size();
        en = 1'b1; req_valid = '0;
        step();
        req_valid = '1;
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        en = 1'b0; req_valid = '0;
        n_cmp++;
        if (g_id.size() - gb != 3 || g_cyc[g_id.size()-1] - g_cyc[g_id.size()-2] != 2) begin
            n_fail++; $display("FAIL abort_resume: got %0d grants need 3 with one-cycle gap", g_id.size() - gb);
        end
        got = 0;
        for (int t = 0; t < 15 && !got; t++) begin
            step();
            if (idle === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got || r_id.size() - rb != 3) begin
            n_fail++; $display("FAIL abort_done: got idle=%b rsps=%0d need idle=1 rsps=3", idle, r_id.size() - rb);
        end
    endtask

    task automatic test_reset_mid();
        int gb, rb;
        gb = g_id.size();
        en = 1'b1; req_valid = '0;
        step();
        req_valid = '1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (g_id.size() - gb != 2 || core_a !== 1'b0 || core_b !== 8'h00 || rsp_valid !== 1'b0 ||
            idle !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_now: got grants=%0d a=%b b=%h rv=%b idle=%b ready=%b need 2 0 00 0 1 0000",
                     g_id.size() - gb, core_a, core_b, rsp_valid, idle, req_ready);
        end
        rb = r_id.size();
        repeat (3) step();
        rst_n = 1'b1; en = 1'b0; req_valid = '0;
        repeat (CORE_LAT + 6) step();
        n_cmp++;
        if (r_id.size() != rb) begin
            n_fail++; $display("FAIL reset_mid_rsp: got %0d responses need 0", r_id.size() - rb);
        end
    endtask

    task automatic test_wrap();
        int gb;
        bit got;
        reset_dut();
        gb = g_id.size();
        en = 1'b1; req_valid = 4'b1000;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (g_id.size() > gb) begin got = 1; req_valid = 4'b0001; end
        end
        step();
        req_valid = '0;
        n_cmp++;
        if (!got || g_id.size() - gb != 2 || g_id[gb] != 3 || g_id[gb+1] != 0 || g_cyc[gb+1] - g_cyc[gb] != 1) begin
            n_fail++; $display("FAIL wrap: got %0d grants need 3 then 0 on consecutive cycles", g_id.size() - gb);
        end
        en = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_random();
        int rb0, gb0;
        bit got;
        gb0 = g_id.size(); rb0 = r_id.size();
        for (int t = 0; t < 500; t++) begin
            en = ($urandom_range(0, 9) != 0);
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'($urandom);
            step();
        end
        en = 1'b0; req_valid = '0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (idle === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got || (r_id.size() - rb0) != (g_id.size() - gb0)) begin
            n_fail++;
            $display("FAIL random_drain: got idle=%b rsps=%0d need idle=1 rsps=%0d",
                     idle, r_id.size() - rb0, g_id.size() - gb0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drain();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
